// File: rtl/regs_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regs_wr_arbiter_pkg
// Shared definitions for the general-register write-port arbiter.
//   RegAddrBus / RegBus : default register address / data widths
//   ZeroReg             : hard-wired zero register index
//   WriteEnable/Disable : write-enable levels of the register file port
//   RstEnable           : active level of the reset input
//   wrSrc_e             : which writer currently owns the write port
// ---------------------------------------------------------------------------
package regs_wr_arbiter_pkg;

   localparam int RegAddrBus = 5;
   localparam int RegBus = 32;
   localparam int StarveLimitDefault = 8;

   localparam logic WriteEnable = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic RstEnable = 1'b1;

   localparam logic [RegAddrBus-1:0] ZeroReg = '0;

   typedef enum logic [1:0] {
      SrcNone,
      SrcEx,
      SrcDiv,
      SrcJtag
   } wrSrc_e;

endpackage

// File: rtl/regs_wr_slot.sv
// ---------------------------------------------------------------------------
// regs_wr_slot
// One-entry holding slot for a deferred register write.
//   clk, rst     : clock, asynchronous active-high reset
//   i_req        : writer request (addr/data valid)
//   i_addr/i_data: write address / data to capture
//   i_grant      : write port granted to this slot this cycle (slot drains)
//   o_ack        : one-cycle pulse the cycle after a capture
//   o_full       : slot holds a pending write
//   o_addr/o_data: pending write address / data
//   o_aged       : slot is full and has waited the starvation limit
//   o_agedNext   : slot will be aged in the next cycle
// ---------------------------------------------------------------------------
module regs_wr_slot
   import regs_wr_arbiter_pkg::*;
#(
   parameter int ADDR_W = RegAddrBus,
   parameter int DATA_W = RegBus,
   parameter int STARVE_LIMIT = StarveLimitDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_grant,
   output logic              o_ack,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_aged,
   output logic              o_agedNext
);

   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AgeLimit = AGE_W'(STARVE_LIMIT);

   logic              r_full;
   logic              r_ack;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [AGE_W-1:0]  r_age;
   logic [AGE_W-1:0]  w_ageNext;

   // Next age: cleared when the slot drains, otherwise a full slot counts
   // the cycles it has been passed over, saturating at the limit. An empty
   // slot always sits at zero, so a fresh capture starts counting from 0.
   always_comb begin
      w_ageNext = r_age;
      if (i_grant) begin
         w_ageNext = '0;
      end else if (r_full && (r_age < AgeLimit)) begin
         w_ageNext = r_age + AGE_W'(1);
      end
   end

   // Capture and drain. The ack flag blocks a second capture while the
   // requester is still dropping its request. A granted slot is full, so
   // it can never capture in the same cycle it drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_full <= 1'b0;
         r_ack  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_age  <= '0;
      end else begin
         r_ack <= 1'b0;
         if (i_grant) begin
            r_full <= 1'b0;
         end else if (i_req && !r_full && !r_ack) begin
            r_full <= 1'b1;
            r_ack  <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
         end
         r_age <= w_ageNext;
      end
   end

   assign o_ack      = r_ack;
   assign o_full     = r_full;
   assign o_addr     = r_addr;
   assign o_data     = r_data;
   assign o_aged     = r_full && (r_age >= AgeLimit);
   assign o_agedNext = (w_ageNext >= AgeLimit);

endmodule

// File: rtl/regs_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wr_arbiter
// Shares the general-register write port between ex writeback (zero
// latency), divider writeback and jtag debug writes (both via holding slots).
//   clk, rst                       : clock, asynchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i  : ex writeback
//   div_req_i/div_addr_i/div_data_i: divider write request, div_ack_o pulse
//   jtag_req_i/jtag_addr_i/jtag_data_i: jtag write request, jtag_ack_o pulse
//   div_pend_o/div_pend_addr_o     : divider slot occupancy for hazard stall
//   hold_o                         : ex must not write next cycle
//   err_o                          : sticky "ex wrote during hold" error
//   we_o/waddr_o/wdata_o           : register file write port
// ---------------------------------------------------------------------------
module regs_wr_arbiter
   import regs_wr_arbiter_pkg::*;
#(
   parameter int ADDR_W = RegAddrBus,
   parameter int DATA_W = RegBus,
   parameter int STARVE_LIMIT = StarveLimitDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_we_i,
   input  logic [ADDR_W-1:0] ex_waddr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              div_req_i,
   input  logic [ADDR_W-1:0] div_addr_i,
   input  logic [DATA_W-1:0] div_data_i,
   output logic              div_ack_o,
   input  logic              jtag_req_i,
   input  logic [ADDR_W-1:0] jtag_addr_i,
   input  logic [DATA_W-1:0] jtag_data_i,
   output logic              jtag_ack_o,
   output logic              div_pend_o,
   output logic [ADDR_W-1:0] div_pend_addr_o,
   output logic              hold_o,
   output logic              err_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o
);

   localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZeroReg);

   wrSrc_e            w_src;
   logic              w_grantDiv;
   logic              w_grantJtag;
   logic              w_divFull;
   logic [ADDR_W-1:0] w_divAddr;
   logic [DATA_W-1:0] w_divData;
   logic              w_divAged;
   logic              w_divAgedNext;
   logic              w_jtagFull;
   logic [ADDR_W-1:0] w_jtagAddr;
   logic [DATA_W-1:0] w_jtagData;
   logic              w_jtagAged;
   logic              w_jtagAgedNext;
   logic              r_hold;
   logic              r_err;

   regs_wr_slot #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) uDivSlot (
      .clk(clk),
      .rst(rst),
      .i_req(div_req_i),
      .i_addr(div_addr_i),
      .i_data(div_data_i),
      .i_grant(w_grantDiv),
      .o_ack(div_ack_o),
      .o_full(w_divFull),
      .o_addr(w_divAddr),
      .o_data(w_divData),
      .o_aged(w_divAged),
      .o_agedNext(w_divAgedNext)
   );

   regs_wr_slot #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) uJtagSlot (
      .clk(clk),
      .rst(rst),
      .i_req(jtag_req_i),
      .i_addr(jtag_addr_i),
      .i_data(jtag_data_i),
      .i_grant(w_grantJtag),
      .o_ack(jtag_ack_o),
      .o_full(w_jtagFull),
      .o_addr(w_jtagAddr),
      .o_data(w_jtagData),
      .o_aged(w_jtagAged),
      .o_agedNext(w_jtagAgedNext)
   );

   // Port owner: ex always wins; a starved jtag slot jumps ahead of the
   // divider; otherwise the divider is preferred over jtag. The divider is
   // never starved by jtag, only by ex, so only jtag needs the aged bypass.
   always_comb begin
      w_src = SrcNone;
      if (ex_we_i) begin
         w_src = SrcEx;
      end else if (w_jtagAged) begin
         w_src = SrcJtag;
      end else if (w_divFull) begin
         w_src = SrcDiv;
      end else if (w_jtagFull) begin
         w_src = SrcJtag;
      end
   end

   assign w_grantDiv  = (w_src == SrcDiv);
   assign w_grantJtag = (w_src == SrcJtag);

   // Drive the register file port. A slot targeting the zero register is
   // still granted so it drains, but the write enable is suppressed.
   always_comb begin
      we_o    = WriteDisable;
      waddr_o = '0;
      wdata_o = '0;
      case (w_src)
         SrcEx: begin
            we_o    = WriteEnable;
            waddr_o = ex_waddr_i;
            wdata_o = ex_wdata_i;
         end
         SrcDiv: begin
            we_o    = (w_divAddr != ZeroAddr);
            waddr_o = w_divAddr;
            wdata_o = w_divData;
         end
         SrcJtag: begin
            we_o    = (w_jtagAddr != ZeroAddr);
            waddr_o = w_jtagAddr;
            wdata_o = w_jtagData;
         end
         default: begin
            we_o    = WriteDisable;
         end
      endcase
   end

   // Hold tracks the slots' next-cycle aged state, so it appears together
   // with the aged slot and falls right after that slot drains. The error
   // flag latches any ex write attempted while hold is up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_hold <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_hold <= w_divAgedNext || w_jtagAgedNext;
         if (ex_we_i && r_hold) begin
            r_err <= 1'b1;
         end
      end
   end

   assign hold_o          = r_hold;
   assign err_o           = r_err;
   assign div_pend_o      = w_divFull;
   assign div_pend_addr_o = w_divAddr;

   // The divider aged flag only feeds hold through its next-state version.
   logic w_unusedDivAged;
   assign w_unusedDivAged = w_divAged;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_wr_arbiter
// Directed, table-driven bench for regs_wr_arbiter. Each record is one
// clock cycle: inputs driven after an edge, outputs compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_regs_wr_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int STARVE_LIMIT = 8;

   typedef struct {
      logic              exWe;
      logic [ADDR_W-1:0] exAddr;
      logic [DATA_W-1:0] exData;
      logic              divReq;
      logic [ADDR_W-1:0] divAddr;
      logic [DATA_W-1:0] divData;
      logic              jtagReq;
      logic [ADDR_W-1:0] jtagAddr;
      logic [DATA_W-1:0] jtagData;
      logic              eWe;
      logic [ADDR_W-1:0] eWaddr;
      logic [DATA_W-1:0] eWdata;
      logic              eDivAck;
      logic              eJtagAck;
      logic              eDivPend;
      logic [ADDR_W-1:0] ePendAddr;
      logic              eHold;
      logic              eErr;
   } vec_t;

   logic              clk;
   logic              rst;
   logic              exWe;
   logic [ADDR_W-1:0] exAddr;
   logic [DATA_W-1:0] exData;
   logic              divReq;
   logic [ADDR_W-1:0] divAddr;
   logic [DATA_W-1:0] divData;
   logic              divAck;
   logic              jtagReq;
   logic [ADDR_W-1:0] jtagAddr;
   logic [DATA_W-1:0] jtagData;
   logic              jtagAck;
   logic              divPend;
   logic [ADDR_W-1:0] divPendAddr;
   logic              hold;
   logic              err;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   int checkCount = 0;
   int errorCount = 0;
   vec_t vecs[16];

   regs_wr_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ex_we_i(exWe),
      .ex_waddr_i(exAddr),
      .ex_wdata_i(exData),
      .div_req_i(divReq),
      .div_addr_i(divAddr),
      .div_data_i(divData),
      .div_ack_o(divAck),
      .jtag_req_i(jtagReq),
      .jtag_addr_i(jtagAddr),
      .jtag_data_i(jtagData),
      .jtag_ack_o(jtagAck),
      .div_pend_o(divPend),
      .div_pend_addr_o(divPendAddr),
      .hold_o(hold),
      .err_o(err),
      .we_o(we),
      .waddr_o(waddr),
      .wdata_o(wdata)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(
      input logic exWeV, input int exAddrV, input int exDataV,
      input logic divReqV, input int divAddrV, input int divDataV,
      input logic jtagReqV, input int jtagAddrV, input int jtagDataV,
      input logic eWeV, input int eWaddrV, input int eWdataV,
      input logic eDivAckV, input logic eJtagAckV,
      input logic eDivPendV, input int ePendAddrV,
      input logic eHoldV, input logic eErrV);
      vec_t v;
      v.exWe      = exWeV;
      v.exAddr    = ADDR_W'(exAddrV);
      v.exData    = DATA_W'(exDataV);
      v.divReq    = divReqV;
      v.divAddr   = ADDR_W'(divAddrV);
      v.divData   = DATA_W'(divDataV);
      v.jtagReq   = jtagReqV;
      v.jtagAddr  = ADDR_W'(jtagAddrV);
      v.jtagData  = DATA_W'(jtagDataV);
      v.eWe       = eWeV;
      v.eWaddr    = ADDR_W'(eWaddrV);
      v.eWdata    = DATA_W'(eWdataV);
      v.eDivAck   = eDivAckV;
      v.eJtagAck  = eJtagAckV;
      v.eDivPend  = eDivPendV;
      v.ePendAddr = ADDR_W'(ePendAddrV);
      v.eHold     = eHoldV;
      v.eErr      = eErrV;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exWe     = v.exWe;
      exAddr   = v.exAddr;
      exData   = v.exData;
      divReq   = v.divReq;
      divAddr  = v.divAddr;
      divData  = v.divData;
      jtagReq  = v.jtagReq;
      jtagAddr = v.jtagAddr;
      jtagData = v.jtagData;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      checkVal({tag, ".we"}, 32'(we), 32'(v.eWe));
      if (v.eWe) begin
         checkVal({tag, ".waddr"}, 32'(waddr), 32'(v.eWaddr));
         checkVal({tag, ".wdata"}, wdata, v.eWdata);
      end
      checkVal({tag, ".divAck"}, 32'(divAck), 32'(v.eDivAck));
      checkVal({tag, ".jtagAck"}, 32'(jtagAck), 32'(v.eJtagAck));
      checkVal({tag, ".divPend"}, 32'(divPend), 32'(v.eDivPend));
      if (v.eDivPend) begin
         checkVal({tag, ".divPendAddr"}, 32'(divPendAddr), 32'(v.ePendAddr));
      end
      checkVal({tag, ".hold"}, 32'(hold), 32'(v.eHold));
      checkVal({tag, ".err"}, 32'(err), 32'(v.eErr));
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic runVec(input vec_t v, input string tag);
      applyStimulus(v);
      #2;
      checkOutput(v, tag);
      stepClock();
   endtask

   initial begin
      // Basic traffic after reset; one record per cycle.
      //            exWe a  d            dReq a  d     jReq a  d     eWe a  d            dAk jAk pnd pa hold err
      vecs[0]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[1]  = mkVec(1, 5, 'hDEADBEEF, 0, 0, 0,      0, 0, 0,      1, 5, 'hDEADBEEF,   0, 0, 0, 0, 0, 0);
      vecs[2]  = mkVec(0, 0, 0,          1, 7, 'h12,   0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[3]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      1, 7, 'h12,         1, 0, 1, 7, 0, 0);
      vecs[4]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[5]  = mkVec(0, 0, 0,          1, 3, 'h33,   1, 4, 'h44,   0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[6]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      1, 3, 'h33,         1, 1, 1, 3, 0, 0);
      vecs[7]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      1, 4, 'h44,         0, 0, 0, 0, 0, 0);
      vecs[8]  = mkVec(0, 0, 0,          0, 0, 0,      1, 0, 'h55,   0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[9]  = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      0, 0, 0,            0, 1, 0, 0, 0, 0);
      vecs[10] = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 0);
      vecs[11] = mkVec(1, 0, 'h77,       0, 0, 0,      0, 0, 0,      1, 0, 'h77,         0, 0, 0, 0, 0, 0);
      vecs[12] = mkVec(1, 1, 'h1,        1, 10, 'hA,   0, 0, 0,      1, 1, 'h1,          0, 0, 0, 0, 0, 0);
      vecs[13] = mkVec(1, 2, 'h2,        0, 0, 0,      0, 0, 0,      1, 2, 'h2,          1, 0, 1, 10, 0, 0);
      vecs[14] = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      1, 10, 'hA,         0, 0, 1, 10, 0, 0);
      vecs[15] = mkVec(0, 0, 0,          0, 0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0, 0);

      rst = 1'b1;
      applyStimulus(vecs[0]);
      #2;
      checkOutput(vecs[0], "reset");
      stepClock();
      stepClock();
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         runVec(vecs[i], $sformatf("vec%0d", i));
      end

      // Starvation: jtag captured while ex writes every cycle. After the
      // capture edge, eight waiting cycles age the slot to the limit.
      runVec(mkVec(1, 1, 'h100, 0, 0, 0, 1, 9, 'h99, 1, 1, 'h100, 0, 0, 0, 0, 0, 0), "starve0");
      runVec(mkVec(1, 1, 'h100, 0, 0, 0, 0, 0, 0,    1, 1, 'h100, 0, 1, 0, 0, 0, 0), "starve1");
      for (int i = 2; i <= 8; i++) begin
         runVec(mkVec(1, 1, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 'h100, 0, 0, 0, 0, 0, 0),
                $sformatf("starve%0d", i));
      end
      runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h99, 0, 0, 0, 0, 1, 0), "starveDrain");
      runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0), "starveHoldFall");

      // Protocol error: ex keeps writing in the cycle hold is up.
      runVec(mkVec(1, 2, 'h2, 0, 0, 0, 1, 12, 'hC, 1, 2, 'h2, 0, 0, 0, 0, 0, 0), "err0");
      runVec(mkVec(1, 2, 'h2, 0, 0, 0, 0, 0, 0,    1, 2, 'h2, 0, 1, 0, 0, 0, 0), "err1");
      for (int i = 2; i <= 8; i++) begin
         runVec(mkVec(1, 2, 'h2, 0, 0, 0, 0, 0, 0, 1, 2, 'h2, 0, 0, 0, 0, 0, 0),
                $sformatf("err%0d", i));
      end
      runVec(mkVec(1, 3, 'h3, 0, 0, 0, 0, 0, 0, 1, 3, 'h3,  0, 0, 0, 0, 1, 0), "errExWins");
      runVec(mkVec(0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 12, 'hC, 0, 0, 0, 0, 1, 1), "errSet");
      runVec(mkVec(0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1), "errSticky0");
      runVec(mkVec(0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1), "errSticky1");

      // Reset mid-operation: fill both slots and age them until hold rises.
      runVec(mkVec(1, 1, 'h1, 1, 5, 'h55, 1, 6, 'h66, 1, 1, 'h1, 0, 0, 0, 0, 0, 1), "fill0");
      runVec(mkVec(1, 1, 'h1, 0, 0, 0,    0, 0, 0,    1, 1, 'h1, 1, 1, 1, 5, 0, 1), "fill1");
      for (int i = 2; i <= 8; i++) begin
         runVec(mkVec(1, 1, 'h1, 0, 0, 0, 0, 0, 0, 1, 1, 'h1, 0, 0, 1, 5, 0, 1),
                $sformatf("fill%0d", i));
      end
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      checkVal("preRst.hold", 32'(hold), 32'd1);
      checkVal("preRst.divPend", 32'(divPend), 32'd1);
      checkVal("preRst.we", 32'(we), 32'd1);
      checkVal("preRst.waddr", 32'(waddr), 32'd6);
      rst = 1'b1;
      #1;
      checkVal("asyncRst.hold", 32'(hold), 32'd0);
      checkVal("asyncRst.err", 32'(err), 32'd0);
      checkVal("asyncRst.divPend", 32'(divPend), 32'd0);
      checkVal("asyncRst.divAck", 32'(divAck), 32'd0);
      checkVal("asyncRst.jtagAck", 32'(jtagAck), 32'd0);
      checkVal("asyncRst.we", 32'(we), 32'd0);
      stepClock();
      rst = 1'b0;
      runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "postRst0");
      runVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "postRst1");
      runVec(mkVec(1, 8, 'h88, 0, 0, 0, 0, 0, 0, 1, 8, 'h88, 0, 0, 0, 0, 0, 0), "postRstEx");

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/regs_wr_arbiter.md
Name: regs_wr_arbiter

Overview:
- Shares the single general-register write port between three writers: ex writeback, multi-cycle divider writeback and jtag debug writes.
- Sits between those writers and the general register file, driving its we/waddr/wdata inputs.
- ex always has a zero-latency path. Divider and jtag requests are captured into one-entry holding slots and drained on idle ex cycles.
- A starvation counter forces a one-cycle pipeline hold so that slots always make progress.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_LIMIT, 8, cycles a full slot may wait before hold_o is raised (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_we_i  in  1  ex write enable.
- ex_waddr_i  in  ADDR_W  ex write address.
- ex_wdata_i  in  DATA_W  ex write data.
- div_req_i  in  1  divider write request.
- div_addr_i  in  ADDR_W  divider destination.
- div_data_i  in  DATA_W  divider result.
- div_ack_o  out  1  one-cycle pulse: divider request captured.
- jtag_req_i  in  1  jtag write request.
- jtag_addr_i  in  ADDR_W  jtag destination.
- jtag_data_i  in  DATA_W  jtag data.
- jtag_ack_o  out  1  one-cycle pulse: jtag request captured.
- div_pend_o  out  1  divider slot full (used by id for hazard stall).
- div_pend_addr_o  out  ADDR_W  divider slot address.
- hold_o  out  1  request to pipeline: ex must not write next cycle.
- err_o  out  1  sticky protocol error.
- we_o  out  1  to register file: write enable.
- waddr_o  out  ADDR_W  to register file: write address.
- wdata_o  out  DATA_W  to register file: write data.

Behaviour:
- Reset (async, rst=1):
  - Both slots empty; age counters 0.
  - div_ack_o, jtag_ack_o, hold_o, err_o all 0.
  - Requests in flight are dropped; requesters re-issue after reset.
  - we_o follows ex_we_i combinationally; it is 0 while ex_we_i=0.
- Capture:
  - At a clk edge where req_i=1, the slot is empty and that slot's ack_o=0: load addr/data into the slot.
  - ack_o is registered and is 1 for exactly the following cycle.
  - The requester must drop req_i in the cycle ack_o=1. The slot ignores req_i while ack_o=1, which prevents a double capture.
- Write-port mux (combinational, latency 0 for ex):
  - ex_we_i=1: ex drives the port.
  - Otherwise, jtag slot if it is full and its age ≥ STARVE_LIMIT.
  - Otherwise, div slot if full.
  - Otherwise, jtag slot if full.
  - Otherwise, we_o=0.
- Drain:
  - The granted slot empties at the end of its grant cycle; its age resets to 0.
  - Earliest slot write is the cycle after capture, i.e. the same cycle as ack_o.
- Zero register:
  - A slot with addr 0 is still captured and acked, and is granted per priority.
  - During that grant, we_o=0 and the slot clears.
  - ex writes to addr 0 pass through unchanged; the register file ignores them.
- Age:
  - Each full, non-granted slot increments its age per cycle, saturating at STARVE_LIMIT.
  - Counter width is $clog2(STARVE_LIMIT+1).
- Hold:
  - hold_o = registered (any slot age ≥ STARVE_LIMIT). It drops the cycle after the aged slot drains.
  - While hold_o=1, ex_we_i must be 0. If ex_we_i=1 and hold_o=1, ex still wins and err_o is set; only rst clears err_o.
- Simultaneous events:
  - div and jtag requests on the same edge: both are captured independently.
  - Capture and drain of different slots in the same cycle is legal.
  - A slot cannot capture and drain in the same cycle, because it is empty while capturing.
- WAW hazard:
  - Not resolved here. id must stall any instruction writing div_pend_addr_o while div_pend_o=1.
  - jtag writes are debug-only and unordered with ex.

Decomposition:
- Shared package / defines: ADDR_W/DATA_W aliases of the existing RegAddrBus/RegBus, ZeroReg, WriteEnable, RstEnable constants.
- Natural sub-module: regs_wr_slot, instanced twice. It holds a one-entry slot with req/ack capture, age counter, full flag and a grant input.
- The top level holds the priority mux, hold_o and err_o.

Test Plan:
- Direct ex path: ex_we_i=1, addr=5, data=0xDEADBEEF -> same cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; no acks.
- Divider idle capture: div_req_i=1, addr=7, data=0x12 at edge k, ex idle -> div_ack_o=1 and we_o=1/waddr_o=7/wdata_o=0x12 in cycle k+1; div_pend_o=0 from k+2.
- Simultaneous slot requests: div (addr 3) and jtag (addr 4) requests at the same edge, ex idle -> both acked next cycle; div written first, jtag one cycle later.
- Starvation: jtag (addr 9) captured, ex_we_i held 1 -> hold_o rises after STARVE_LIMIT=8 waiting cycles. Release ex_we_i -> jtag is written that cycle, and hold_o falls the cycle after.
- Zero-register and protocol error: jtag req to addr 0 -> jtag_ack_o pulses, we_o stays 0, slot clears. Separately, ex_we_i=1 while hold_o=1 -> err_o sets and stays 1 until rst.
- Reset mid-operation: assert rst asynchronously with both slots full and hold_o=1 -> all outputs and flags are 0 immediately, before any clk edge. After release, no stale write appears on we_o.
